// File: rtl/cnn16_mem_arbiter.sv
// cnn16_mem_arbiter
// Shares the single CNN16 RAM port between the processor core and the host
// loader. One access is sequenced at a time: arbitrate in IDLE, strobe the
// RAM in ISSUE, wait out the read latency in WAIT, pulse *_ready in DONE.
//
// Parameters: ADDR_W address width, DATA_W data width, RD_LAT read latency (1..3).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   core_req/we/addr/wdata        core request (held until core_ready)
//   core_rdata, core_ready        core read data and completion pulse
//   ld_req/we/addr/wdata          loader request (held until ld_ready)
//   ld_rdata, ld_ready            loader read data and completion pulse
//   mem_en/we/addr/wdata          registered RAM command
//   mem_rdata                     RAM read data
//   owner                         00 none, 01 core, 10 loader
//
// Build option: define CNN16_ARB_RR_EN for round-robin conflict resolution;
// otherwise the loader has fixed priority on a conflict.

module cnn16_mem_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ready,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CORE = 2'b01;
  localparam logic [1:0] OWN_LD   = 2'b10;

  state_t     state;
  logic [1:0] lat_cnt;
  logic       last_ld;     // last_owner: 0 = core, 1 = loader
  logic       grant_ld_c;

  // Loader wins when it is the only requester or when the conflict rule picks it
  always_comb begin
    grant_ld_c = 1'b0;
`ifdef CNN16_ARB_RR_EN
    grant_ld_c = ld_req && (!core_req || !last_ld);
`else
    grant_ld_c = ld_req;
`endif
  end

  // Transaction sequencer with registered RAM command and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= 2'd0;
      last_ld    <= 1'b0;
      owner      <= OWN_NONE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
      ld_rdata   <= '0;
      core_ready <= 1'b0;
      ld_ready   <= 1'b0;
    end else begin
      mem_en     <= 1'b0;
      core_ready <= 1'b0;
      ld_ready   <= 1'b0;
      case (state)
        IDLE: begin
          owner <= OWN_NONE;
          if (core_req || ld_req) begin
            owner     <= grant_ld_c ? OWN_LD : OWN_CORE;
            mem_we    <= grant_ld_c ? ld_we : core_we;
            mem_addr  <= grant_ld_c ? ld_addr : core_addr;
            mem_wdata <= grant_ld_c ? ld_wdata : core_wdata;
            mem_en    <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_we) begin
            core_ready <= (owner == OWN_CORE);
            ld_ready   <= (owner == OWN_LD);
            state      <= DONE;
          end else begin
            lat_cnt <= 2'(RD_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            if (owner == OWN_LD) ld_rdata <= mem_rdata;
            else                 core_rdata <= mem_rdata;
            core_ready <= (owner == OWN_CORE);
            ld_ready   <= (owner == OWN_LD);
            state      <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        DONE: begin
          last_ld <= (owner == OWN_LD);
          owner   <= OWN_NONE;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
